// File: rtl/macs_seq_pkg.sv
// Shared types and default latencies for the Macs row sequencer.
package macs_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } seq_state_e;

  localparam int RD_LAT_DEF   = 1;
  localparam int MACS_LAT_DEF = 2;

  // Cycles spent in DRAIN between the last issue cycle and the WRITE cycle.
  function automatic int drain_cycles(input int rd_lat, input int macs_lat);
    return rd_lat + macs_lat - 1;
  endfunction

endpackage

// File: rtl/macs_seq_delay.sv
// Fixed-depth shift register, cleared by reset. Aligns issue-side strobes
// with RAM read data. DEPTH must be at least 1.
module macs_seq_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the input through DEPTH register stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/macs_sequencer.sv
// Sequences one matrix-row x vector pass through the Macs datapath: linear
// A/B reads, Macs strobes aligned to RAM latency, one result write per row.
// Build macro MACS_SEQ_PERF_CNT_EN adds the perf_cycles busy-cycle counter.
//
// state | meaning
// IDLE  | waiting for start; config latched when start arrives
// ISSUE | one A read and one B read per cycle for the current row
// DRAIN | waiting for RAM and Macs pipelines to deliver the row result
// WRITE | row result written to mem0 at c_base + row
// FIN   | one-cycle done pulse, then back to IDLE
module macs_sequencer
  import macs_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 12,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int MACS_LAT   = MACS_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_a_base,
  input  logic [ADDR_WIDTH-1:0] cfg_b_base,
  input  logic [ADDR_WIDTH-1:0] cfg_c_base,
  input  logic [CNT_WIDTH-1:0]  cfg_rows,
  input  logic [CNT_WIDTH-1:0]  cfg_cols,
  input  logic                  cfg_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  a_rd_en,
  output logic [ADDR_WIDTH-1:0] a_rd_addr,
  output logic                  b_rd_en,
  output logic [ADDR_WIDTH-1:0] b_rd_addr,
  output logic                  macs_en,
  output logic                  macs_mode,
  output logic                  macs_signal,
  input  logic [63:0]           macs_result,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [63:0]           wr_data
`ifdef MACS_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  // DRAIN lasts DRAIN_CYC cycles, so the counter is loaded one below that
  // and WRITE follows the cycle in which it reads zero. Assumes the combined
  // latency RD_LAT + MACS_LAT is at least 2.
  localparam int         DRAIN_CYC  = drain_cycles(RD_LAT, MACS_LAT);
  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYC - 1);

  seq_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0]  row_q, row_d;
  logic [CNT_WIDTH-1:0]  col_q, col_d;
  logic [ADDR_WIDTH-1:0] a_ptr_q, a_ptr_d;
  logic [7:0]            drain_q, drain_d;

  logic [ADDR_WIDTH-1:0] a_base_q, b_base_q, c_base_q;
  logic [CNT_WIDTH-1:0]  rows_q, cols_q;
  logic                  mode_q;

  logic accept;
  logic issue;
  logic writing;
  logic last_col;
  logic last_row;
  logic [1:0] align_in, align_out;

  assign accept   = (state_q == IDLE) && start;
  assign issue    = (state_q == ISSUE);
  assign writing  = (state_q == WRITE);
  assign last_col = (col_q == cols_q - 1'b1);
  assign last_row = (row_q == rows_q - 1'b1);

  // Config is captured only when a job is accepted; start while busy is ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      mode_q   <= 1'b0;
    end else if (accept) begin
      a_base_q <= cfg_a_base;
      b_base_q <= cfg_b_base;
      c_base_q <= cfg_c_base;
      rows_q   <= cfg_rows;
      cols_q   <= cfg_cols;
      mode_q   <= cfg_mode;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      a_ptr_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      a_ptr_q <= a_ptr_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and counter update. The A pointer runs continuously across
  // rows, so it equals a_base + row*cols + col without a multiplier.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    a_ptr_d = a_ptr_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((cfg_rows == '0) || (cfg_cols == '0)) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            row_d   = '0;
            col_d   = '0;
            a_ptr_d = cfg_a_base;
          end
        end
      end
      ISSUE: begin
        a_ptr_d = a_ptr_q + 1'b1;
        if (last_col) begin
          col_d   = '0;
          drain_d = DRAIN_LOAD;
          state_d = DRAIN;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = WRITE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      WRITE: begin
        if (last_row) begin
          state_d = FIN;
        end else begin
          row_d   = row_q + 1'b1;
          col_d   = '0;
          state_d = ISSUE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // macs_en and macs_signal ride the same pipe as the read data.
  assign align_in = {issue, issue && (col_q == '0)};

  macs_seq_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_align (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (align_in),
    .q_o  (align_out)
  );

  assign macs_en     = align_out[1];
  assign macs_signal = align_out[0];

  // Port outputs decoded from state; addresses and data are zero when idle.
  always_comb begin
    busy      = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == WRITE);
    done      = (state_q == FIN);
    a_rd_en   = issue;
    b_rd_en   = issue;
    a_rd_addr = '0;
    b_rd_addr = '0;
    wr_en     = writing;
    wr_addr   = '0;
    wr_data   = '0;
    macs_mode = 1'b0;
    if (busy) macs_mode = mode_q;
    if (issue) begin
      a_rd_addr = a_ptr_q;
      b_rd_addr = b_base_q + ADDR_WIDTH'(col_q);
    end
    if (writing) begin
      wr_addr = c_base_q + ADDR_WIDTH'(row_q);
      wr_data = macs_result;
    end
  end

`ifdef MACS_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // Busy-cycle count for the current/last job: cleared on accept, saturating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/macs_sequencer.md
Name: macs_sequencer

Overview:
- Sequences one matrix-row × vector pass through the Macs datapath.
- Issues linear reads on one port of each dual-port RAM (A from mem1, B from mem0) and drives macs_en/macs_mode/macs_signal aligned to the RAM read latency.
- Writes each row's 64-bit Macs result back through the mem0 write port.
- Sits between Control (issues start/config on a matmul instruction) and the RAM/Macs ports it owns while busy.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width.
- CNT_WIDTH, 12, width of row/column counters.
- RD_LAT, 1, RAM read latency in cycles (rd_en to data valid).
- MACS_LAT, 2, Macs latency from last macs_en to result valid.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches config
- cfg_a_base  in  ADDR_WIDTH  first A word address (mem1)
- cfg_b_base  in  ADDR_WIDTH  first B word address (mem0)
- cfg_c_base  in  ADDR_WIDTH  first result word address (mem0)
- cfg_rows  in  CNT_WIDTH  number of rows
- cfg_cols  in  CNT_WIDTH  64-bit words per row
- cfg_mode  in  1  passed to macs_mode for the whole job
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- a_rd_en  out  1  mem1 read strobe
- a_rd_addr  out  ADDR_WIDTH  mem1 read address
- b_rd_en  out  1  mem0 read strobe
- b_rd_addr  out  ADDR_WIDTH  mem0 read address
- macs_en  out  1  Macs operand-valid
- macs_mode  out  1  Macs mode
- macs_signal  out  1  first operand of row; Macs clears accumulator
- macs_result  in  64  Macs result
- wr_en  out  1  mem0 write strobe
- wr_addr  out  ADDR_WIDTH  result address
- wr_data  out  64  result data (= macs_result when wr_en)

Behaviour:
- Reset (async, rstn low): state IDLE; all outputs 0; counters and latched config 0. Takes effect immediately, including mid-job. No done pulse is produced for an aborted job.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, FIN.
- IDLE:
  - start=1 latches cfg_*.
  - If cfg_rows==0 or cfg_cols==0, go to FIN (no memory access).
  - Otherwise go to ISSUE with row=0, col=0.
- ISSUE (busy=1):
  - a_rd_en=b_rd_en=1.
  - a_rd_addr = a_base + row*cols + col, kept as a running pointer that continues across rows.
  - b_rd_addr = b_base + col.
  - col increments each cycle; at col==cols-1, go to DRAIN.
- Alignment pipeline: macs_en = a_rd_en delayed RD_LAT cycles. macs_signal = (col==0 issue) delayed the same. macs_mode = latched cfg_mode while busy, else 0.
- DRAIN: waits until exactly RD_LAT+MACS_LAT cycles after the last issue cycle, then goes to WRITE.
- WRITE (one cycle):
  - wr_en=1, wr_addr = c_base + row, wr_data = macs_result.
  - If row==rows-1, go to FIN; else row++, col=0, go to ISSUE.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Timing:
  - Row period = cols + RD_LAT + MACS_LAT cycles; rows are not overlapped.
  - start accepted at cycle k: first rd_en in cycle k+1; done in cycle k+1 + rows*(cols+RD_LAT+MACS_LAT).
- start while busy: ignored; config unchanged.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error flag.
- wr_data = 0 when wr_en=0.

Optional Feature:
- Macro MACS_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output port perf_cycles [31:0]: count of busy cycles in the last completed job.
  - The counter clears on start and holds after done; reset value 0; saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package macs_seq_pkg holds:
  - state enum (IDLE/ISSUE/DRAIN/WRITE/FIN);
  - default latency constants RD_LAT_DEF=1, MACS_LAT_DEF=2.
- One sub-module, macs_seq_delay: parameterised-depth shift register with reset-to-0, used for the macs_en/macs_signal alignment.

Test Plan:
- Defaults; start with rows=2, cols=4, a_base=0x010, b_base=0x100, c_base=0x200, mode=1 -> rd_en high cycles k+1..k+4 and k+8..k+11. a_rd_addr 0x010..0x017; b_rd_addr 0x100..0x103 twice. macs_signal at k+2 and k+9. wr_en at k+7 (addr 0x200) and k+14 (addr 0x201). done at k+15.
- rows=3, cols=0 -> no rd_en/wr_en; done at k+1; busy stays 0.
- start re-pulsed mid-job with different config -> outputs identical to an uninterrupted run; only one done pulse.
- rstn deasserted mid-ISSUE, then start rows=1, cols=1 -> outputs 0 immediately; no done for the aborted job. The new job writes c_base at k+4, done at k+5.
- a_base=0xFFE, rows=1, cols=4 -> a_rd_addr sequence FFE, FFF, 000, 001.
- MACS_SEQ_PERF_CNT_EN defined, rows=2, cols=4 -> perf_cycles=14 after done, holding until the next start.
